// File: rtl/axi_lite_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_rr_arbiter
// Purpose  : Round-robin arbiter sharing one AXI4-Lite port among CORES_COUNT
//            masters, one transaction in flight. Optional response watchdog is
//            enabled by defining AXI_ARB_WATCHDOG_EN.
// Revision : 1.0
// ============================================================================
module axi_lite_rr_arbiter #(
    parameter int CORES_COUNT    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       resetn,

    input  logic [CORES_COUNT-1:0]     core_axi_awvalid,
    output logic [CORES_COUNT-1:0]     core_axi_awready,
    input  logic [32*CORES_COUNT-1:0]  core_axi_awaddr,
    input  logic [3*CORES_COUNT-1:0]   core_axi_awprot,
    input  logic [CORES_COUNT-1:0]     core_axi_wvalid,
    output logic [CORES_COUNT-1:0]     core_axi_wready,
    input  logic [32*CORES_COUNT-1:0]  core_axi_wdata,
    input  logic [4*CORES_COUNT-1:0]   core_axi_wstrb,
    output logic [CORES_COUNT-1:0]     core_axi_bvalid,
    input  logic [CORES_COUNT-1:0]     core_axi_bready,
    input  logic [CORES_COUNT-1:0]     core_axi_arvalid,
    output logic [CORES_COUNT-1:0]     core_axi_arready,
    input  logic [32*CORES_COUNT-1:0]  core_axi_araddr,
    input  logic [3*CORES_COUNT-1:0]   core_axi_arprot,
    output logic [CORES_COUNT-1:0]     core_axi_rvalid,
    input  logic [CORES_COUNT-1:0]     core_axi_rready,
    output logic [31:0]                core_axi_rdata,

    output logic                       mem_axi_awvalid,
    input  logic                       mem_axi_awready,
    output logic [31:0]                mem_axi_awaddr,
    output logic [2:0]                 mem_axi_awprot,
    output logic                       mem_axi_wvalid,
    input  logic                       mem_axi_wready,
    output logic [31:0]                mem_axi_wdata,
    output logic [3:0]                 mem_axi_wstrb,
    input  logic                       mem_axi_bvalid,
    output logic                       mem_axi_bready,
    output logic                       mem_axi_arvalid,
    input  logic                       mem_axi_arready,
    output logic [31:0]                mem_axi_araddr,
    output logic [2:0]                 mem_axi_arprot,
    input  logic                       mem_axi_rvalid,
    output logic                       mem_axi_rready,
    input  logic [31:0]                mem_axi_rdata,

    output logic [CORES_COUNT-1:0]     grant,
    output logic                       timeout_err
);

    localparam int IDX_W = (CORES_COUNT > 1) ? $clog2(CORES_COUNT) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_RESP = 3'd2,
        S_WR_ADDR = 3'd3,
        S_WR_RESP = 3'd4
    } state_t;

    state_t                   state_q;
    logic [CORES_COUNT-1:0]   grant_q;
    logic [IDX_W-1:0]         last_q;
    logic                     aw_done_q;
    logic                     w_done_q;

    logic [CORES_COUNT-1:0]   w_req;
    logic                     w_found;
    logic [IDX_W-1:0]         w_pick;
    logic [CORES_COUNT-1:0]   w_pick_oh;
    logic                     w_rd_addr, w_rd_resp, w_wr_addr, w_wr_resp;
    logic                     w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
    logic                     w_timeout;
    logic [CORES_COUNT-1:0]   w_fake_r, w_fake_b;
    logic                     w_fake_r_busy, w_fake_b_busy;

    function automatic logic [IDX_W-1:0] f_wrap(input int v);
        f_wrap = IDX_W'(v % CORES_COUNT);
    endfunction

    assign w_req = core_axi_arvalid | core_axi_awvalid;

    // Scan starts just above the last owner so it gets lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= CORES_COUNT; k++) begin
            if (!w_found && w_req[f_wrap(int'(last_q) + k)]) begin
                w_found = 1'b1;
                w_pick  = f_wrap(int'(last_q) + k);
            end
        end
    end

    assign w_pick_oh = CORES_COUNT'(1) << w_pick;

    assign w_rd_addr = (state_q == S_RD_ADDR);
    assign w_rd_resp = (state_q == S_RD_RESP);
    assign w_wr_addr = (state_q == S_WR_ADDR);
    assign w_wr_resp = (state_q == S_WR_RESP);

    assign mem_axi_arvalid  = w_rd_addr & core_axi_arvalid[last_q];
    assign mem_axi_araddr   = core_axi_araddr[32*last_q +: 32];
    assign mem_axi_arprot   = core_axi_arprot[3*last_q +: 3];
    assign core_axi_arready = grant_q & {CORES_COUNT{w_rd_addr & mem_axi_arready}};

    assign mem_axi_rready  = w_rd_resp & core_axi_rready[last_q] & ~w_fake_r_busy;
    assign core_axi_rvalid = (grant_q & {CORES_COUNT{w_rd_resp & mem_axi_rvalid & ~w_fake_r_busy}})
                           | w_fake_r;
    assign core_axi_rdata  = w_fake_r_busy ? 32'hDEAD_BEEF : mem_axi_rdata;

    // Each write channel is masked once its own handshake has completed.
    assign mem_axi_awvalid  = w_wr_addr & ~aw_done_q & core_axi_awvalid[last_q];
    assign mem_axi_awaddr   = core_axi_awaddr[32*last_q +: 32];
    assign mem_axi_awprot   = core_axi_awprot[3*last_q +: 3];
    assign core_axi_awready = grant_q & {CORES_COUNT{w_wr_addr & ~aw_done_q & mem_axi_awready}};

    assign mem_axi_wvalid  = w_wr_addr & ~w_done_q & core_axi_wvalid[last_q];
    assign mem_axi_wdata   = core_axi_wdata[32*last_q +: 32];
    assign mem_axi_wstrb   = core_axi_wstrb[4*last_q +: 4];
    assign core_axi_wready = grant_q & {CORES_COUNT{w_wr_addr & ~w_done_q & mem_axi_wready}};

    assign mem_axi_bready  = w_wr_resp & core_axi_bready[last_q] & ~w_fake_b_busy;
    assign core_axi_bvalid = (grant_q & {CORES_COUNT{w_wr_resp & mem_axi_bvalid & ~w_fake_b_busy}})
                           | w_fake_b;

    assign w_ar_hs = mem_axi_arvalid & mem_axi_arready;
    assign w_r_hs  = mem_axi_rvalid  & mem_axi_rready;
    assign w_aw_hs = mem_axi_awvalid & mem_axi_awready;
    assign w_w_hs  = mem_axi_wvalid  & mem_axi_wready;
    assign w_b_hs  = mem_axi_bvalid  & mem_axi_bready;

    assign grant = grant_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            last_q    <= IDX_W'(CORES_COUNT - 1);
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_found) begin
                        grant_q <= w_pick_oh;
                        last_q  <= w_pick;
                        state_q <= core_axi_arvalid[w_pick] ? S_RD_ADDR : S_WR_ADDR;
                    end
                end
                S_RD_ADDR: begin
                    if (w_ar_hs) state_q <= S_RD_RESP;
                end
                S_RD_RESP: begin
                    if (w_r_hs || w_timeout) begin
                        state_q <= S_IDLE;
                        grant_q <= '0;
                    end
                end
                S_WR_ADDR: begin
                    if ((aw_done_q || w_aw_hs) && (w_done_q || w_w_hs)) begin
                        state_q   <= S_WR_RESP;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end else begin
                        if (w_aw_hs) aw_done_q <= 1'b1;
                        if (w_w_hs)  w_done_q  <= 1'b1;
                    end
                end
                S_WR_RESP: begin
                    if (w_b_hs || w_timeout) begin
                        state_q <= S_IDLE;
                        grant_q <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

`ifdef AXI_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]         wd_cnt_q;
    logic [CORES_COUNT-1:0]   fake_r_q;
    logic [CORES_COUNT-1:0]   fake_b_q;
    logic                     timeout_q;
    logic                     w_in_resp;

    assign w_in_resp = w_rd_resp | w_wr_resp;
    assign w_timeout = w_in_resp & (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) & ~(w_r_hs | w_b_hs);

    // Counter is zero on the first response cycle since ADDR states keep it cleared.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wd_cnt_q  <= '0;
            fake_r_q  <= '0;
            fake_b_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= w_in_resp ? wd_cnt_q + 1'b1 : '0;
            fake_r_q  <= (fake_r_q & ~core_axi_rready)
                       | (grant_q & {CORES_COUNT{w_timeout & w_rd_resp}});
            fake_b_q  <= (fake_b_q & ~core_axi_bready)
                       | (grant_q & {CORES_COUNT{w_timeout & w_wr_resp}});
            if (w_timeout) timeout_q <= 1'b1;
        end
    end

    assign w_fake_r      = fake_r_q;
    assign w_fake_b      = fake_b_q;
    assign w_fake_r_busy = |fake_r_q;
    assign w_fake_b_busy = |fake_b_q;
    assign timeout_err   = timeout_q;
`else
    assign w_timeout     = 1'b0;
    assign w_fake_r      = '0;
    assign w_fake_b      = '0;
    assign w_fake_r_busy = 1'b0;
    assign w_fake_b_busy = 1'b0;
    assign timeout_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_rr_arbiter
// Purpose  : Scoreboard bench for axi_lite_rr_arbiter with two masters and a
//            simple AXI4-Lite slave model.
// Revision : 1.0
// ============================================================================
module tb_axi_lite_rr_arbiter;

    localparam int N   = 2;
    localparam int TMO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic resetn;

    logic [N-1:0]    c_awvalid, c_awready, c_wvalid, c_wready, c_bvalid, c_bready;
    logic [N-1:0]    c_arvalid, c_arready, c_rvalid, c_rready;
    logic [32*N-1:0] c_awaddr, c_wdata, c_araddr;
    logic [3*N-1:0]  c_awprot, c_arprot;
    logic [4*N-1:0]  c_wstrb;
    logic [31:0]     c_rdata;

    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic [N-1:0] grant;
    logic         timeout_err;

    axi_lite_rr_arbiter #(.CORES_COUNT(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resetn(resetn),
        .core_axi_awvalid(c_awvalid), .core_axi_awready(c_awready),
        .core_axi_awaddr(c_awaddr), .core_axi_awprot(c_awprot),
        .core_axi_wvalid(c_wvalid), .core_axi_wready(c_wready),
        .core_axi_wdata(c_wdata), .core_axi_wstrb(c_wstrb),
        .core_axi_bvalid(c_bvalid), .core_axi_bready(c_bready),
        .core_axi_arvalid(c_arvalid), .core_axi_arready(c_arready),
        .core_axi_araddr(c_araddr), .core_axi_arprot(c_arprot),
        .core_axi_rvalid(c_rvalid), .core_axi_rready(c_rready),
        .core_axi_rdata(c_rdata),
        .mem_axi_awvalid(m_awvalid), .mem_axi_awready(m_awready),
        .mem_axi_awaddr(m_awaddr), .mem_axi_awprot(m_awprot),
        .mem_axi_wvalid(m_wvalid), .mem_axi_wready(m_wready),
        .mem_axi_wdata(m_wdata), .mem_axi_wstrb(m_wstrb),
        .mem_axi_bvalid(m_bvalid), .mem_axi_bready(m_bready),
        .mem_axi_arvalid(m_arvalid), .mem_axi_arready(m_arready),
        .mem_axi_araddr(m_araddr), .mem_axi_arprot(m_arprot),
        .mem_axi_rvalid(m_rvalid), .mem_axi_rready(m_rready),
        .mem_axi_rdata(m_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct { int core; logic [31:0] data; } rd_exp_t;
    typedef struct { int core; logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wr_exp_t;
    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];
    int      op_q[$];

    task automatic exp_rd(input int c, input logic [31:0] d);
        rd_exp_t e;
        e.core = c; e.data = d;
        rd_q.push_back(e);
    endtask

    // Op code at the memory side: 16*kind + core, kind 1 = read, 2 = write.
    task automatic exp_op(input int kind, input int c);
        op_q.push_back(16 * kind + c);
    endtask

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return (a == 32'h100) ? 32'h1234_5678 : (a ^ 32'hCAFE_0000);
    endfunction

    // Slave model: always ready, one-cycle response latency.
    logic        s_mute, s_rvalid, s_bvalid, s_aw_got, s_w_got;
    logic [31:0] s_rdata, s_cap_addr, s_cap_data;
    logic [3:0]  s_cap_strb;
    assign m_rvalid = s_rvalid;
    assign m_rdata  = s_rdata;
    assign m_bvalid = s_bvalid;

    always @(posedge clk) begin
        if (!resetn) begin
            s_rvalid <= 1'b0; s_bvalid <= 1'b0; s_aw_got <= 1'b0; s_w_got <= 1'b0;
        end else begin
            if (m_arvalid && m_arready) begin
                if (!s_mute) begin
                    s_rvalid <= 1'b1;
                    s_rdata  <= slave_data(m_araddr);
                end
            end else if (s_rvalid && m_rready) begin
                s_rvalid <= 1'b0;
            end
            if (m_awvalid && m_awready) begin s_cap_addr <= m_awaddr; s_aw_got <= 1'b1; end
            if (m_wvalid && m_wready) begin s_cap_data <= m_wdata; s_cap_strb <= m_wstrb; s_w_got <= 1'b1; end
            if (s_aw_got && s_w_got && !s_bvalid) begin
                s_bvalid <= 1'b1; s_aw_got <= 1'b0; s_w_got <= 1'b0;
            end else if (s_bvalid && m_bready) begin
                s_bvalid <= 1'b0;
            end
        end
    end

    int aw_hs_cnt = 0;
    int w_hs_cnt  = 0;
    int route_viol = 0;

    always @(negedge clk) begin
        int idx;
        int gi;
        int e;
        if (resetn) begin
            gi = 0;
            for (int i = 0; i < N; i++) if (grant[i]) gi = i;
            for (int i = 0; i < N; i++) begin
                if (c_rvalid[i] && c_rready[i]) begin
                    idx = -1;
                    for (int j = 0; j < rd_q.size(); j++) if (idx < 0 && rd_q[j].core == i) idx = j;
                    if (idx < 0) check("rd_orphan", 64'(i), 64'hFF);
                    else begin
                        check("rdata", c_rdata, rd_q[idx].data);
                        rd_q.delete(idx);
                    end
                end
                if (c_bvalid[i] && c_bready[i]) begin
                    idx = -1;
                    for (int j = 0; j < wr_q.size(); j++) if (idx < 0 && wr_q[j].core == i) idx = j;
                    if (idx < 0) check("wr_orphan", 64'(i), 64'hFF);
                    else begin
                        check("wr_addr", s_cap_addr, wr_q[idx].addr);
                        check("wr_data", s_cap_data, wr_q[idx].data);
                        check("wr_strb", s_cap_strb, wr_q[idx].strb);
                        wr_q.delete(idx);
                    end
                end
            end
            if (m_arvalid && m_arready) begin
                if (op_q.size() == 0) check("op_extra_rd", 64'(16 + gi), 64'h0);
                else begin e = op_q.pop_front(); check("op_order", 64'(16 + gi), 64'(e)); end
            end
            if (m_awvalid && m_awready) begin
                aw_hs_cnt++;
                if (op_q.size() == 0) check("op_extra_wr", 64'(32 + gi), 64'h0);
                else begin e = op_q.pop_front(); check("op_order", 64'(32 + gi), 64'(e)); end
            end
            if (m_wvalid && m_wready) w_hs_cnt++;
            if (!timeout_err && (((c_rvalid | c_bvalid | c_arready | c_awready | c_wready) & ~grant) != '0))
                route_viol++;
        end
    end

    task automatic do_read(input int c, input logic [31:0] a, input bit wait_resp);
        int n;
        bit hs;
        c_araddr[32*c +: 32] = a;
        c_arprot[3*c +: 3]   = 3'(c);
        c_arvalid[c]         = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 200) begin
            @(negedge clk); hs = c_arready[c];
            @(posedge clk); #1; n++;
        end
        c_arvalid[c] = 1'b0;
        if (!hs) check("ar_wait", 0, 1);
        if (wait_resp) begin
            n = 0; hs = 1'b0;
            while (!hs && n < 200) begin
                @(negedge clk); hs = c_rvalid[c] & c_rready[c];
                @(posedge clk); #1; n++;
            end
            if (!hs) check("r_wait", 0, 1);
        end
    endtask

    task automatic do_write(input int c, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int wdelay);
        int n;
        bit hs_aw, hs_w, hs_b;
        wr_exp_t e;
        e.core = c; e.addr = a; e.data = d; e.strb = s;
        wr_q.push_back(e);
        c_awaddr[32*c +: 32] = a;
        c_awprot[3*c +: 3]   = 3'(c);
        c_wdata[32*c +: 32]  = d;
        c_wstrb[4*c +: 4]    = s;
        c_awvalid[c]         = 1'b1;
        if (wdelay == 0) c_wvalid[c] = 1'b1;
        n = 0;
        while ((c_awvalid[c] || c_wvalid[c] || n < wdelay) && n < 200) begin
            @(negedge clk);
            hs_aw = c_awvalid[c] & c_awready[c];
            hs_w  = c_wvalid[c] & c_wready[c];
            @(posedge clk); #1;
            if (hs_aw) c_awvalid[c] = 1'b0;
            if (hs_w)  c_wvalid[c]  = 1'b0;
            n++;
            if (n == wdelay) c_wvalid[c] = 1'b1;
        end
        if (c_awvalid[c] || c_wvalid[c]) check("aw_w_wait", 0, 1);
        c_awvalid[c] = 1'b0; c_wvalid[c] = 1'b0;
        n = 0; hs_b = 1'b0;
        while (!hs_b && n < 200) begin
            @(negedge clk); hs_b = c_bvalid[c] & c_bready[c];
            @(posedge clk); #1; n++;
        end
        if (!hs_b) check("b_wait", 0, 1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_grant"}, grant, '0);
        check({tag, "_mem"}, {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, '0);
        check({tag, "_core"}, {c_arready, c_awready, c_wready, c_rvalid, c_bvalid}, '0);
    endtask

    initial begin
        int aw0, w0, n;
        c_awvalid = '0; c_wvalid = '0; c_arvalid = '0;
        c_bready = '1;  c_rready = '1;
        c_awaddr = '0;  c_wdata = '0;  c_araddr = '0;
        c_awprot = '0;  c_arprot = '0; c_wstrb = '0;
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        s_mute = 1'b0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        check("reset_timeout_err", timeout_err, 0);
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;

        // Single read: one bubble before mem arvalid, then data back to core 0
        exp_rd(0, 32'h1234_5678);
        exp_op(1, 0);
        fork
            do_read(0, 32'h100, 1'b1);
            begin
                @(negedge clk);
                check("arvalid_bubble", m_arvalid, 0);
                @(negedge clk);
                check("arvalid_rise", m_arvalid, 1);
                check("araddr", m_araddr, 32'h100);
                check("grant_single", grant, 2'b01);
            end
        join
        @(negedge clk);
        check("grant_idle", grant, 2'b00);
        @(posedge clk); #1;

        // Write on core 1 with W trailing AW by 3 cycles
        aw0 = aw_hs_cnt; w0 = w_hs_cnt;
        exp_op(2, 1);
        do_write(1, 32'h0020_0000, 32'd123456789, 4'hF, 3);
        check("aw_hs_once", 64'(aw_hs_cnt - aw0), 1);
        check("w_hs_once", 64'(w_hs_cnt - w0), 1);

        // Contention: both cores read back-to-back, grants alternate
        exp_op(1, 0); exp_op(1, 1); exp_op(1, 0); exp_op(1, 1);
        exp_rd(0, slave_data(32'h1000)); exp_rd(0, slave_data(32'h1004));
        exp_rd(1, slave_data(32'h2000)); exp_rd(1, slave_data(32'h2004));
        fork
            begin do_read(0, 32'h1000, 1'b1); do_read(0, 32'h1004, 1'b1); end
            begin do_read(1, 32'h2000, 1'b1); do_read(1, 32'h2004, 1'b1); end
        join

        // Same-cycle read and write on core 0: read goes first
        exp_op(1, 0); exp_op(2, 0);
        exp_rd(0, slave_data(32'h3000));
        fork
            do_read(0, 32'h3000, 1'b1);
            do_write(0, 32'h3100, 32'hA5A5_5A5A, 4'h3, 0);
        join

        // Reset while waiting for read data
        s_mute = 1'b1;
        exp_op(1, 0);
        do_read(0, 32'h4000, 1'b0);
        @(negedge clk);
        check("grant_rd_resp", grant, 2'b01);
        check("rready_rd_resp", m_rready, 1);
        @(posedge clk); #1 resetn = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        check_quiet("midreset");
        s_mute = 1'b0;
        @(posedge clk); #1;
        exp_op(1, 0); exp_op(1, 1);
        exp_rd(0, slave_data(32'h5000)); exp_rd(1, slave_data(32'h6000));
        fork
            do_read(0, 32'h5000, 1'b1);
            do_read(1, 32'h6000, 1'b1);
        join

`ifdef AXI_ARB_WATCHDOG_EN
        // Silent slave: fake response after TMO cycles, then core 1 is served
        s_mute = 1'b1;
        exp_op(1, 0);
        exp_rd(0, 32'hDEAD_BEEF);
        fork
            do_read(0, 32'h7000, 1'b1);
            begin
                n = 0;
                while (!(m_arvalid && m_arready) && n < 100) begin @(negedge clk); n++; end
                @(posedge clk);
                n = 0;
                forever begin
                    @(negedge clk);
                    if (c_rvalid[0] || n > 100) break;
                    @(posedge clk);
                    n++;
                end
                check("wd_latency", 64'(n), 64'(TMO));
            end
        join
        check("timeout_err_set", timeout_err, 1);
        s_mute = 1'b0;
        exp_op(1, 1);
        exp_rd(1, slave_data(32'h7100));
        do_read(1, 32'h7100, 1'b1);
        check("timeout_err_sticky", timeout_err, 1);
`else
        check("timeout_err_off", timeout_err, 0);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rd_q_drained", 64'(rd_q.size()), 0);
        check("wr_q_drained", 64'(wr_q.size()), 0);
        check("op_q_drained", 64'(op_q.size()), 0);
        check("routing", 64'(route_viol), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
